// File: rtl/audio_mix_pkg.sv
// Shared constants, FSM encoding and the output saturator for the 48 kHz audio mixer.
package audio_mix_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int DMA_SHIFT = 8;
  localparam int GAIN_W    = 6;
  localparam int PSG_W     = 10;
  localparam int DMA_W     = 8;
  localparam int PROD_W    = 26;

  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(32767);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-32768);

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    SUM_L,
    MUL_L,
    SUM_R,
    MUL_R,
    OUT
  } state_e;

  function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [PROD_W-1:0] v);
    if (v > SAT_MAX) begin
      return SAMPLE_W'(SAT_MAX);
    end else if (v < SAT_MIN) begin
      return SAMPLE_W'(SAT_MIN);
    end
    return v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/audio_mix_if.sv
// Sample-source side of the mixer: PSG/DMA inputs, gains, and the L/R sample outputs.
interface audio_mix_if;
  import audio_mix_pkg::*;

  logic        [PSG_W-1:0]    psg_in;
  logic signed [DMA_W-1:0]    dma_l;
  logic signed [DMA_W-1:0]    dma_r;
  logic                       dma_valid;
  logic                       dma_mute;
  logic        [GAIN_W-1:0]   gain_l;
  logic        [GAIN_W-1:0]   gain_r;
  logic signed [SAMPLE_W-1:0] audio_l;
  logic signed [SAMPLE_W-1:0] audio_r;
  logic                       sample_strobe;

  modport master (
    output psg_in, dma_l, dma_r, dma_valid, dma_mute, gain_l, gain_r,
    input  audio_l, audio_r, sample_strobe
  );

  modport slave (
    input  psg_in, dma_l, dma_r, dma_valid, dma_mute, gain_l, gain_r,
    output audio_l, audio_r, sample_strobe
  );

endinterface

// File: rtl/audio_tick_gen.sv
// Fractional accumulator: emits exactly SAMPLE_HZ single-cycle ticks per CLK_HZ clock cycles.
module audio_tick_gen #(
  parameter int unsigned CLK_HZ    = 32000000,
  parameter int unsigned SAMPLE_HZ = 48000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int ACC_W = 25;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   acc_sum;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_sum = {1'b0, acc_q} + (ACC_W+1)'(SAMPLE_HZ);
    acc_d   = acc_sum[ACC_W-1:0];
    tick    = 1'b0;
    if (acc_sum >= (ACC_W+1)'(CLK_HZ)) begin
      acc_d = ACC_W'(acc_sum - (ACC_W+1)'(CLK_HZ));
      tick  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/audio_mix_48k.sv
// Mixes PSG and STE DMA sound into saturated signed 16-bit L/R samples at an exact 48 kHz.
// PSG DC is removed by a leaky average; one registered multiplier is shared by both channels.
module audio_mix_48k
  import audio_mix_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 32000000,
  parameter int unsigned SAMPLE_HZ = 48000,
  parameter int unsigned DC_SHIFT  = 8
) (
  input  logic       clk,
  input  logic       reset,
  audio_mix_if.slave bus
);
  localparam int AC_W      = 17;
  localparam int SUM_W     = 18;
  localparam int PSG_SCALE = 5;

  if (CLK_HZ / SAMPLE_HZ < 8) begin : g_ratio_check
    $error("audio_mix_48k: CLK_HZ/SAMPLE_HZ must be at least 8");
  end

  state_e                     state_q, state_d;
  logic                       tick;
  logic signed [DMA_W-1:0]    hold_l_q, hold_r_q;
  logic signed [AC_W-1:0]     avg_q;
  logic signed [SAMPLE_W-1:0] audio_l_q, audio_r_q;
  logic                       strobe_q;

  logic signed [AC_W-1:0]     ac_q;
  logic signed [DMA_W-1:0]    snap_l_q, snap_r_q;
  logic                       mute_q;
  logic        [GAIN_W-1:0]   gain_l_q, gain_r_q;
  logic signed [SUM_W-1:0]    sum_q;
  logic signed [PROD_W-1:0]   prod_q;
  logic signed [SAMPLE_W-1:0] res_l_q;

  logic signed [AC_W-1:0]     psg_x, psg_ac;
  logic signed [DMA_W-1:0]    dma_sel;
  logic signed [SUM_W-1:0]    dma_term, sum_d;
  logic        [GAIN_W-1:0]   gain_sel;
  logic signed [GAIN_W+1:0]   gain_mul;
  logic signed [PROD_W-1:0]   prod_d, prod_scaled;
  logic signed [SAMPLE_W-1:0] prod_sat;

  audio_tick_gen #(
    .CLK_HZ   (CLK_HZ),
    .SAMPLE_HZ(SAMPLE_HZ)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_comb begin
    psg_x       = $signed({{(AC_W-PSG_W-PSG_SCALE){1'b0}}, bus.psg_in, {PSG_SCALE{1'b0}}});
    psg_ac      = psg_x - avg_q;
    dma_sel     = (state_q == SUM_L) ? snap_l_q : snap_r_q;
    dma_term    = mute_q ? '0
                : $signed({{(SUM_W-DMA_W-DMA_SHIFT){dma_sel[DMA_W-1]}}, dma_sel, {DMA_SHIFT{1'b0}}});
    sum_d       = $signed({{(SUM_W-AC_W){ac_q[AC_W-1]}}, ac_q}) + dma_term;
    gain_sel    = (state_q == MUL_L) ? gain_l_q : gain_r_q;
    gain_mul    = $signed({2'b00, gain_sel} + (GAIN_W+2)'(1));
    prod_d      = PROD_W'(sum_q) * PROD_W'(gain_mul);
    prod_scaled = prod_q >>> GAIN_W;
    prod_sat    = sat_sample(prod_scaled);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = SNAP;
      SNAP:    state_d = SUM_L;
      SUM_L:   state_d = MUL_L;
      MUL_L:   state_d = SUM_R;
      SUM_R:   state_d = MUL_R;
      MUL_R:   state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      avg_q     <= '0;
      audio_l_q <= '0;
      audio_r_q <= '0;
      strobe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      strobe_q <= (state_q == OUT);
      if (bus.dma_valid) begin
        hold_l_q <= bus.dma_l;
        hold_r_q <= bus.dma_r;
      end
      if (state_q == SNAP) avg_q <= avg_q + (psg_ac >>> DC_SHIFT);
      if (state_q == OUT) begin
        audio_l_q <= res_l_q;
        audio_r_q <= prod_sat;
      end
    end
  end

  // NOTE: pipeline registers are left unreset; each is rewritten before the FSM consumes it.
  always_ff @(posedge clk) begin
    case (state_q)
      SNAP: begin
        ac_q     <= psg_ac;
        snap_l_q <= hold_l_q;
        snap_r_q <= hold_r_q;
        mute_q   <= bus.dma_mute;
        gain_l_q <= bus.gain_l;
        gain_r_q <= bus.gain_r;
      end
      SUM_L, SUM_R: sum_q  <= sum_d;
      MUL_L, MUL_R: prod_q <= prod_d;
      default: ;
    endcase
    // prod_q still holds the left product while the right sum is formed
    if (state_q == SUM_R) res_l_q <= prod_sat;
  end

  assign bus.audio_l       = audio_l_q;
  assign bus.audio_r       = audio_r_q;
  assign bus.sample_strobe = strobe_q;

endmodule

// File: tb/tb_audio_mix_48k.sv
// Directed bench for audio_mix_48k: a fast-ratio instance for datapath work, a default one for timing.
`timescale 1ns/1ps
module tb_audio_mix_48k;
  import audio_mix_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_f, rst_d;
  logic [9:0]        psg;
  logic signed [7:0] dl, dr;
  logic              dv, mute;
  logic [5:0]        gl, gr;

  int n_checks = 0;
  int n_fail   = 0;

  audio_mix_if bus_f();
  audio_mix_if bus_d();

  assign bus_f.psg_in = psg;  assign bus_d.psg_in = psg;
  assign bus_f.dma_l = dl;    assign bus_d.dma_l = dl;
  assign bus_f.dma_r = dr;    assign bus_d.dma_r = dr;
  assign bus_f.dma_valid = dv; assign bus_d.dma_valid = dv;
  assign bus_f.dma_mute = mute; assign bus_d.dma_mute = mute;
  assign bus_f.gain_l = gl;   assign bus_d.gain_l = gl;
  assign bus_f.gain_r = gr;   assign bus_d.gain_r = gr;

  audio_mix_48k #(.CLK_HZ(480), .SAMPLE_HZ(48), .DC_SHIFT(8)) dut_f (
    .clk(clk), .reset(rst_f), .bus(bus_f)
  );

  audio_mix_48k dut_d (
    .clk(clk), .reset(rst_d), .bus(bus_d)
  );

  typedef struct {
    int psg; int dl; int dr; int mute; int gl; int gr;
    int exp_l; int exp_r;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic reset_dut(input bit sel);
    if (sel) rst_d = 1'b1; else rst_f = 1'b1;
    repeat (2) cyc();
    if (sel) rst_d = 1'b0; else rst_f = 1'b0;
  endtask

  task automatic pulse_valid();
    dv = 1'b1;
    cyc();
    dv = 1'b0;
  endtask

  task automatic wait_strobe(input bit sel, input int limit, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      cyc();
      n++;
      seen = sel ? bus_d.sample_strobe : bus_f.sample_strobe;
    end
  endtask

  task automatic wait_state(input bit sel, input state_e s, input int limit, output bit seen);
    int n = 0;
    seen = sel ? (dut_d.state_q == s) : (dut_f.state_q == s);
    while (!seen && n < limit) begin
      cyc();
      n++;
      seen = sel ? (dut_d.state_q == s) : (dut_f.state_q == s);
    end
  endtask

  task automatic drive(input vec_t v);
    psg  = 10'(v.psg);
    dl   = 8'(v.dl);
    dr   = 8'(v.dr);
    mute = v.mute[0];
    gl   = 6'(v.gl);
    gr   = 6'(v.gr);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, cnt, last, bad;
    bit  seen;
    vec_t v;

    vecs[0]  = '{0,    64, -128, 0, 63, 63, 16384, -32768};
    vecs[1]  = '{1023, 127, -128, 0, 63, 63, 32767, -32};
    vecs[2]  = '{512,  100, -100, 1, 63, 63, 16384, 16384};
    vecs[3]  = '{0,    64,   64, 0, 31, 63,  8192, 16384};
    vecs[4]  = '{0,    64,   64, 0,  0, 63,   256, 16384};
    vecs[5]  = '{0,    64,   64, 0, 32, 31,  8448,  8192};
    vecs[6]  = '{0,    -1,    1, 0, 63,  0,  -256,     4};
    vecs[7]  = '{0,    -1, -128, 0,  0, 62,    -4, -32256};
    vecs[8]  = '{1,     0,    0, 0, 63,  1,    32,     1};
    vecs[9]  = '{1023, -128, 127, 0, 63, 63,   -32, 32767};
    vecs[10] = '{1023, 127,  127, 0,  0,  0,  1019,  1019};

    rst_f = 1'b1; rst_d = 1'b1; dv = 1'b0;
    drive(vecs[0]);
    repeat (3) cyc();

    // Reset state of both instances
    check("rst_f_audio_l", bus_f.audio_l, 0);
    check("rst_f_audio_r", bus_f.audio_r, 0);
    check("rst_f_strobe", bus_f.sample_strobe, 0);
    check("rst_d_audio_l", bus_d.audio_l, 0);
    check("rst_d_audio_r", bus_d.audio_r, 0);
    check("rst_d_strobe", bus_d.sample_strobe, 0);

    // Default rate: 3 strobes in a 2000-cycle window, spacing 666/667
    rst_d = 1'b0;
    wait_strobe(1'b1, 800, n, seen);
    check("dflt_first_strobe_seen", seen, 1);
    check("dflt_first_strobe_after_666", (n >= 666), 1);
    cnt = 1; last = 0; bad = 0;
    for (int i = 1; i < 2000; i++) begin
      cyc();
      if (bus_d.sample_strobe) begin
        cnt++;
        if ((i - last) != 666 && (i - last) != 667) bad++;
        last = i;
      end
    end
    check("dflt_strobe_count_2000", cnt, 3);
    check("dflt_strobe_spacing_bad", bad, 0);

    // Reset during MUL_L aborts the sample and restarts the tick interval
    reset_dut(1'b1);
    pulse_valid();
    wait_strobe(1'b1, 800, n, seen);
    check("abort_pre_strobe_seen", seen, 1);
    check("abort_pre_audio_l", bus_d.audio_l, 16384);
    wait_state(1'b1, MUL_L, 800, seen);
    check("abort_mul_l_reached", seen, 1);
    rst_d = 1'b1;
    cyc();
    check("abort_audio_l", bus_d.audio_l, 0);
    check("abort_audio_r", bus_d.audio_r, 0);
    check("abort_strobe", bus_d.sample_strobe, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (bus_d.sample_strobe) bad++;
    end
    check("abort_no_strobe_in_reset", bad, 0);
    rst_d = 1'b0;
    wait_strobe(1'b1, 800, n, seen);
    check("abort_next_strobe_seen", seen, 1);
    check("abort_next_strobe_after_666", (n >= 666), 1);

    // Fast ratio: 100 strobes in 1000 cycles, exactly 10 apart
    reset_dut(1'b0);
    wait_strobe(1'b0, 40, n, seen);
    check("fast_first_strobe_seen", seen, 1);
    cnt = 1; last = 0; bad = 0;
    for (int i = 1; i < 1000; i++) begin
      cyc();
      if (bus_f.sample_strobe) begin
        cnt++;
        if ((i - last) != 10) bad++;
        last = i;
      end
    end
    check("fast_strobe_count_1000", cnt, 100);
    check("fast_strobe_spacing_bad", bad, 0);

    // Table: first sample after reset (DC average still zero)
    foreach (vecs[k]) begin
      v = vecs[k];
      drive(v);
      reset_dut(1'b0);
      pulse_valid();
      wait_strobe(1'b0, 40, n, seen);
      check($sformatf("vec%0d_strobe_seen", k), seen, 1);
      check($sformatf("vec%0d_audio_l", k), bus_f.audio_l, v.exp_l);
      check($sformatf("vec%0d_audio_r", k), bus_f.audio_r, v.exp_r);
    end

    // dma_valid in the SNAP cycle: snapshot keeps the old pair, next sample sees the new one
    drive(vecs[0]);
    reset_dut(1'b0);
    pulse_valid();
    wait_state(1'b0, SNAP, 40, seen);
    check("snap_reached", seen, 1);
    dl = -8'sd64; dr = 8'sd32; dv = 1'b1;
    cyc();
    dv = 1'b0;
    wait_strobe(1'b0, 40, n, seen);
    check("snap_old_audio_l", bus_f.audio_l, 16384);
    check("snap_old_audio_r", bus_f.audio_r, -32768);
    wait_strobe(1'b0, 40, n, seen);
    check("snap_new_audio_l", bus_f.audio_l, -16384);
    check("snap_new_audio_r", bus_f.audio_r, 8192);

    // DC blocker: constant PSG 512, DMA muted
    psg = 10'd512; mute = 1'b1; dl = 8'sd100; dr = -8'sd100; gl = 6'd63; gr = 6'd63;
    reset_dut(1'b0);
    wait_strobe(1'b0, 40, n, seen);
    check("dc_first_audio_l", bus_f.audio_l, 16384);
    check("dc_first_audio_r", bus_f.audio_r, 16384);
    wait_strobe(1'b0, 40, n, seen);
    check("dc_second_audio_l", bus_f.audio_l, 16320);
    bad = 0;
    for (int i = 2; i < 4096; i++) begin
      wait_strobe(1'b0, 40, n, seen);
      if (!seen) bad++;
    end
    check("dc_settle_strobes_missing", bad, 0);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      wait_strobe(1'b0, 40, n, seen);
      if (!seen || bus_f.audio_l >= 256 || bus_f.audio_l <= -256) bad++;
    end
    check("dc_settled_out_of_range", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
